id_ex_alu_decode: RTL and testbench

//  ID-stage producer of the 5-bit ALUCode/operand-select bundle consumed by the EX-stage ALU.

---
 rtl/mips_pkg.sv | 88 ++++++++
 rtl/alu_op_decode.sv | 105 ++++++++++
 rtl/id_ex_alu_decode.sv | 75 +++++++
 tb/tb_id_ex_alu_decode.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the ID-stage ALU decode and the ID/EX pipeline register.
package mips_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_AND  = 5'b00001;
    localparam logic [4:0] ALU_XOR  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_NOR  = 5'b00100;
    localparam logic [4:0] ALU_SUB  = 5'b00101;
    localparam logic [4:0] ALU_ANDI = 5'b00110;
    localparam logic [4:0] ALU_XORI = 5'b00111;
    localparam logic [4:0] ALU_ORI  = 5'b01000;
    localparam logic [4:0] ALU_JR   = 5'b01001;
    localparam logic [4:0] ALU_BEQ  = 5'b01010;
    localparam logic [4:0] ALU_BNE  = 5'b01011;
    localparam logic [4:0] ALU_BGEZ = 5'b01100;
    localparam logic [4:0] ALU_BGTZ = 5'b01101;
    localparam logic [4:0] ALU_BLEZ = 5'b01110;
    localparam logic [4:0] ALU_BLTZ = 5'b01111;
    localparam logic [4:0] ALU_SLL  = 5'b10000;
    localparam logic [4:0] ALU_SRL  = 5'b10001;
    localparam logic [4:0] ALU_SRA  = 5'b10010;
    localparam logic [4:0] ALU_SLT  = 5'b10011;
    localparam logic [4:0] ALU_SLTU = 5'b10100;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    localparam logic [1:0] SRCA_RS    = 2'b00;
    localparam logic [1:0] SRCA_SHAMT = 2'b01;
    localparam logic [1:0] SRCA_C16   = 2'b10;

    typedef struct packed {
        logic [4:0]  alu_code;
        logic [1:0]  src_a;
        logic        src_b;
        logic [31:0] imm32;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        illegal;
    } dec_t;

    typedef struct packed {
        logic        valid;
        dec_t        dec;
        logic [31:0] pc4;
    } idex_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational MIPS instruction -> ALU control bundle decode.
module alu_op_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];

    always_comb begin
        dec           = '0;
        dec.imm32     = sext16(instr[15:0]);
        case (op)
            OP_RTYPE: begin
                dec.write_reg = rd;
                dec.reg_write = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: dec.alu_code = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.alu_code = ALU_SUB;
                    FN_AND:          dec.alu_code = ALU_AND;
                    FN_OR:           dec.alu_code = ALU_OR;
                    FN_XOR:          dec.alu_code = ALU_XOR;
                    FN_NOR:          dec.alu_code = ALU_NOR;
                    FN_SLT:          dec.alu_code = ALU_SLT;
                    FN_SLTU:         dec.alu_code = ALU_SLTU;
                    FN_SLL: begin
                        dec.alu_code = ALU_SLL;
                        dec.src_a    = SRCA_SHAMT;
                    end
                    FN_SRL: begin
                        dec.alu_code = ALU_SRL;
                        dec.src_a    = SRCA_SHAMT;
                    end
                    FN_SRA: begin
                        dec.alu_code = ALU_SRA;
                        dec.src_a    = SRCA_SHAMT;
                    end
                    FN_JR: begin
                        dec.alu_code  = ALU_JR;
                        dec.branch    = 1'b1;
                        dec.reg_write = 1'b0;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
            OP_LUI, OP_LW, OP_SW: begin
                dec.src_b     = 1'b1;
                dec.write_reg = rt;
                dec.reg_write = 1'b1;
                case (op)
                    OP_SLTI:  dec.alu_code = ALU_SLT;
                    OP_SLTIU: dec.alu_code = ALU_SLTU;
                    OP_ANDI:  dec.alu_code = ALU_ANDI;
                    OP_ORI:   dec.alu_code = ALU_ORI;
                    OP_XORI:  dec.alu_code = ALU_XORI;
                    OP_LUI: begin
                        // lui is imm << 16, so the shift amount comes from the constant-16 source
                        dec.alu_code = ALU_SLL;
                        dec.src_a    = SRCA_C16;
                    end
                    OP_LW:    dec.mem_read = 1'b1;
                    OP_SW: begin
                        dec.mem_write = 1'b1;
                        dec.reg_write = 1'b0;
                    end
                    default:  dec.alu_code = ALU_ADD;
                endcase
            end
            OP_BEQ:  begin dec.alu_code = ALU_BEQ;  dec.branch = 1'b1; end
            OP_BNE:  begin dec.alu_code = ALU_BNE;  dec.branch = 1'b1; end
            OP_BLEZ: begin dec.alu_code = ALU_BLEZ; dec.branch = 1'b1; end
            OP_BGTZ: begin dec.alu_code = ALU_BGTZ; dec.branch = 1'b1; end
            OP_REGIMM: begin
                dec.branch = 1'b1;
                if (rt == RT_BGEZ)
                    dec.alu_code = ALU_BGEZ;
                else if (rt == RT_BLTZ)
                    dec.alu_code = ALU_BLTZ;
                else
                    dec.illegal = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        // Illegal encodings keep only the immediate so nothing downstream has side effects.
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            dec.imm32   = sext16(instr[15:0]);
        end
        if (dec.write_reg == 5'd0)
            dec.reg_write = 1'b0;
    end

endmodule

// File: rtl/id_ex_alu_decode.sv
// ID/EX pipeline register for the decoded ALU control bundle, with hold and bubble control.
module id_ex_alu_decode
    import mips_pkg::*;
#(
    parameter bit RESET_PC_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc4,
    input  logic        idex_hold,
    input  logic        idex_bubble,
    output logic        ex_valid,
    output logic [4:0]  ex_ALUCode,
    output logic [1:0]  ex_ALUSrcA,
    output logic        ex_ALUSrcB,
    output logic [31:0] ex_imm32,
    output logic [4:0]  ex_WriteReg,
    output logic        ex_RegWrite,
    output logic        ex_MemRead,
    output logic        ex_MemWrite,
    output logic        ex_Branch,
    output logic        ex_illegal,
    output logic [31:0] ex_pc4
);

    localparam logic [31:0] RST_PC4 = RESET_PC_ZERO ? 32'h0000_0000 : 32'hBFC0_0004;

    dec_t  id_dec;
    idex_t idex_d;
    idex_t idex_q;

    alu_op_decode u_dec (
        .instr (id_instr),
        .dec   (id_dec)
    );

    always_comb begin
        idex_d = idex_q;
        if (!idex_hold) begin
            if (idex_bubble || !id_valid) begin
                idex_d     = '0;
                idex_d.pc4 = id_pc4;
            end else begin
                idex_d.valid = 1'b1;
                idex_d.dec   = id_dec;
                idex_d.pc4   = id_pc4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q     <= '0;
            idex_q.pc4 <= RST_PC4;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ex_valid    = idex_q.valid;
    assign ex_ALUCode  = idex_q.dec.alu_code;
    assign ex_ALUSrcA  = idex_q.dec.src_a;
    assign ex_ALUSrcB  = idex_q.dec.src_b;
    assign ex_imm32    = idex_q.dec.imm32;
    assign ex_WriteReg = idex_q.dec.write_reg;
    assign ex_RegWrite = idex_q.dec.reg_write;
    assign ex_MemRead  = idex_q.dec.mem_read;
    assign ex_MemWrite = idex_q.dec.mem_write;
    assign ex_Branch   = idex_q.dec.branch;
    assign ex_illegal  = idex_q.dec.illegal;
    assign ex_pc4      = idex_q.pc4;

endmodule

// File: tb/tb_id_ex_alu_decode.sv
// Scoreboard bench for id_ex_alu_decode: directed vectors, expected bundles queued per cycle.
module tb_id_ex_alu_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        idex_hold;
    logic        idex_bubble;
    logic        ex_valid;
    logic [4:0]  ex_ALUCode;
    logic [1:0]  ex_ALUSrcA;
    logic        ex_ALUSrcB;
    logic [31:0] ex_imm32;
    logic [4:0]  ex_WriteReg;
    logic        ex_RegWrite;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic        ex_Branch;
    logic        ex_illegal;
    logic [31:0] ex_pc4;

    id_ex_alu_decode dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .idex_hold   (idex_hold),
        .idex_bubble (idex_bubble),
        .ex_valid    (ex_valid),
        .ex_ALUCode  (ex_ALUCode),
        .ex_ALUSrcA  (ex_ALUSrcA),
        .ex_ALUSrcB  (ex_ALUSrcB),
        .ex_imm32    (ex_imm32),
        .ex_WriteReg (ex_WriteReg),
        .ex_RegWrite (ex_RegWrite),
        .ex_MemRead  (ex_MemRead),
        .ex_MemWrite (ex_MemWrite),
        .ex_Branch   (ex_Branch),
        .ex_illegal  (ex_illegal),
        .ex_pc4      (ex_pc4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [82:0] exp;
        logic [82:0] mask;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [82:0] mk(
        input logic v, input logic [4:0] alu, input logic [1:0] sa, input logic sb,
        input logic [31:0] imm, input logic [4:0] wr, input logic rw, input logic mr,
        input logic mw, input logic br, input logic ill, input logic [31:0] pc);
        return {v, alu, sa, sb, imm, wr, rw, mr, mw, br, ill, pc};
    endfunction

    // Mask that ignores WriteReg (branches) or SrcA/SrcB/WriteReg (illegal encodings).
    localparam logic [82:0] M_ALL  = {83{1'b1}};
    logic [82:0] m_nowr;
    logic [82:0] m_ill;

    function automatic logic [82:0] actual();
        return {ex_valid, ex_ALUCode, ex_ALUSrcA, ex_ALUSrcB, ex_imm32, ex_WriteReg,
                ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_illegal, ex_pc4};
    endfunction

    task automatic check(input string name, input logic [82:0] exp, input logic [82:0] mask);
        logic [82:0] act;
        act   = actual();
        total = total + 1;
        if (((act ^ exp) & mask) != '0) begin
            bad = bad + 1;
            $display("FAIL %s: got=%h expected=%h (mask %h)", name, act, exp, mask);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() != 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            check(e.name, e.exp, e.mask);
        end
    end

    // Called at posedge+1: drives one cycle of inputs, queues the bundle expected after the next edge.
    task automatic step(input string name, input logic v, input logic [31:0] instr,
                        input logic [31:0] pc, input logic hold, input logic bub,
                        input logic [82:0] exp, input logic [82:0] mask);
        exp_t e;
        id_valid    = v;
        id_instr    = instr;
        id_pc4      = pc;
        idex_hold   = hold;
        idex_bubble = bub;
        e.due  = cyc + 1;
        e.exp  = exp;
        e.mask = mask;
        e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    logic [82:0] e_lw;
    logic [82:0] e_zero;

    initial begin
        #20000;
        bad = bad + 1;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        m_nowr      = M_ALL;
        m_nowr[41:37] = 5'b0;
        m_ill       = m_nowr;
        m_ill[76:74] = 3'b0;
        e_zero      = '0;
        e_lw        = mk(1, 5'b00000, 2'b00, 1, 32'h4, 5'd8, 1, 1, 0, 0, 0, 32'h10C);

        reset = 1'b1; id_valid = 0; id_instr = '0; id_pc4 = '0; idex_hold = 0; idex_bubble = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", e_zero, M_ALL);
        reset = 1'b0;

        step("add", 1, 32'h012A4020, 32'h100, 0, 0,
             mk(1, 5'b00000, 2'b00, 0, 32'h4020, 5'd8, 1, 0, 0, 0, 0, 32'h100), M_ALL);
        step("sra", 1, 32'h000A4083, 32'h104, 0, 0,
             mk(1, 5'b10010, 2'b01, 0, 32'h4083, 5'd8, 1, 0, 0, 0, 0, 32'h104), M_ALL);
        step("lui", 1, 32'h3C08FFFF, 32'h108, 0, 0,
             mk(1, 5'b10000, 2'b10, 1, 32'hFFFFFFFF, 5'd8, 1, 0, 0, 0, 0, 32'h108), M_ALL);
        step("lw", 1, 32'h8D280004, 32'h10C, 0, 0, e_lw, M_ALL);
        for (int i = 0; i < 3; i++)
            step("hold_lw", 1, 32'h012A4020, 32'h200 + 32'(i), 1, 1, e_lw, M_ALL);
        step("bgez", 1, 32'h05210003, 32'h110, 0, 0,
             mk(1, 5'b01100, 2'b00, 0, 32'h3, 5'd0, 0, 0, 0, 1, 0, 32'h110), m_nowr);
        step("regimm_illegal", 1, 32'h05220003, 32'h114, 0, 0,
             mk(1, 5'b00000, 2'b00, 0, 32'h3, 5'd0, 0, 0, 0, 0, 1, 32'h114), m_ill);
        step("addi_r0", 1, 32'h20000005, 32'h118, 0, 0,
             mk(1, 5'b00000, 2'b00, 1, 32'h5, 5'd0, 0, 0, 0, 0, 0, 32'h118), M_ALL);
        step("bubble", 1, 32'h012A4020, 32'h11C, 0, 1,
             mk(0, 5'b0, 2'b0, 0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 32'h11C), M_ALL);
        step("id_invalid", 0, 32'h8D280004, 32'h120, 0, 0,
             mk(0, 5'b0, 2'b0, 0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 32'h120), M_ALL);
        step("sw", 1, 32'hAD280008, 32'h124, 0, 0,
             mk(1, 5'b00000, 2'b00, 1, 32'h8, 5'd8, 0, 0, 1, 0, 0, 32'h124), M_ALL);
        step("sub", 1, 32'h012A4022, 32'h128, 0, 0,
             mk(1, 5'b00101, 2'b00, 0, 32'h4022, 5'd8, 1, 0, 0, 0, 0, 32'h128), M_ALL);
        step("beq", 1, 32'h11090004, 32'h12C, 0, 0,
             mk(1, 5'b01010, 2'b00, 0, 32'h4, 5'd0, 0, 0, 0, 1, 0, 32'h12C), m_nowr);
        step("slt", 1, 32'h012A402A, 32'h130, 0, 0,
             mk(1, 5'b10011, 2'b00, 0, 32'h402A, 5'd8, 1, 0, 0, 0, 0, 32'h130), M_ALL);
        step("rtype_illegal", 1, 32'h012A4001, 32'h134, 0, 0,
             mk(1, 5'b00000, 2'b00, 0, 32'h4001, 5'd0, 0, 0, 0, 0, 1, 32'h134), m_ill);
        step("lw_again", 1, 32'h8D280004, 32'h10C, 0, 0, e_lw, M_ALL);
        step("hold_before_reset", 1, 32'h012A4020, 32'h300, 1, 0, e_lw, M_ALL);

        // Async reset in the middle of a hold: outputs must clear before the next edge.
        idex_hold = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("reset_mid_hold", e_zero, M_ALL);
        idex_hold = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("first_after_reset", 1, 32'h012A4020, 32'h400, 0, 0,
             mk(1, 5'b00000, 2'b00, 0, 32'h4020, 5'd8, 1, 0, 0, 0, 0, 32'h400), M_ALL);

        @(posedge clk);
        @(posedge clk);
        #1;
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL queue_drain: got=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
